display_address_sequencer: RTL and testbench



---
 rtl/vdg_pkg.sv | 39 +++
 rtl/vdg_mode_decode.sv | 33 +++
 rtl/display_address_sequencer.sv | 128 ++++++++++++
 tb/tb_display_address_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vdg_pkg.sv
// Shared constants and types for the MC6847X display address path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents: graphics mode codes, row widths in bytes, row repeat counts,
// the alpha character height, and the packed {width, repeat} record that
// is produced by the mode decoder.
package vdg_pkg;

  // Graphics mode codes carried on gm while ang=1.
  localparam logic [2:0] GM0 = 3'd0;
  localparam logic [2:0] GM1 = 3'd1;
  localparam logic [2:0] GM2 = 3'd2;
  localparam logic [2:0] GM3 = 3'd3;
  localparam logic [2:0] GM4 = 3'd4;
  localparam logic [2:0] GM5 = 3'd5;
  localparam logic [2:0] GM6 = 3'd6;
  localparam logic [2:0] GM7 = 3'd7;

  // Bytes fetched per stored row.
  localparam logic [5:0] ROW_BYTES_16 = 6'd16;
  localparam logic [5:0] ROW_BYTES_32 = 6'd32;

  // Number of scanlines on which each stored row is shown.
  localparam logic [3:0] REP_1  = 4'd1;
  localparam logic [3:0] REP_2  = 4'd2;
  localparam logic [3:0] REP_3  = 4'd3;
  localparam logic [3:0] REP_12 = 4'd12;

  // Scanlines per alpha character row.
  localparam logic [3:0] ALPHA_ROWS = 4'd12;

  // Per-mode row geometry.
  typedef struct packed {
    logic [5:0] w;  // bytes per stored row
    logic [3:0] r;  // scanlines per stored row
  } mode_cfg_t;

endpackage

// File: rtl/vdg_mode_decode.sv
// Maps {ang, gm} to row geometry (bytes per row, scanlines per row).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs.
//
// Ports:
//   ang_i  in  1 : 0 = alpha/semigraphics, 1 = graphics
//   gm_i   in  3 : graphics mode 0-7 (ignored when ang_i=0)
//   cfg_o  out   : packed {w, r}
module vdg_mode_decode
  import vdg_pkg::*;
(
  input  logic       ang_i,
  input  logic [2:0] gm_i,
  output mode_cfg_t  cfg_o
);

  always_comb begin
    // Alpha geometry is the default: 32 bytes, 12 scanlines per character row.
    cfg_o = '{w: ROW_BYTES_32, r: REP_12};
    if (ang_i) begin
      case (gm_i)
        GM0, GM1: cfg_o = '{w: ROW_BYTES_16, r: REP_3};
        GM2:      cfg_o = '{w: ROW_BYTES_32, r: REP_3};
        GM3:      cfg_o = '{w: ROW_BYTES_16, r: REP_2};
        GM4:      cfg_o = '{w: ROW_BYTES_32, r: REP_2};
        GM5:      cfg_o = '{w: ROW_BYTES_16, r: REP_1};
        GM6, GM7: cfg_o = '{w: ROW_BYTES_32, r: REP_1};
        default:  cfg_o = '{w: ROW_BYTES_32, r: REP_1};
      endcase
    end
  end

endmodule

// File: rtl/display_address_sequencer.sv
// Video RAM fetch address and alpha character-row sequencer.
// Latency: preload/hsn fall/fsn low sampled at edge n take effect at n+1.
// Backpressure: none; preloads past the row width are ignored (da saturates).
//
// Ports:
//   clk, reset_n   : pixel clock, async active-low reset
//   fsn            : frame sync (active low, level); clears all counters
//   hsn            : line sync (active low); falling edge ends a scanline
//   preload        : one strobe per byte fetch
//   ang, gm        : display mode inputs, latched at frame sync / line end
//   da             : fetch address
//   alpha_row      : character scanline 0-11
//   rp             : one-cycle pulse when alpha_row wraps 11 -> 0
module display_address_sequencer
  import vdg_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fsn,
  input  logic              hsn,
  input  logic              preload,
  input  logic              ang,
  input  logic [2:0]        gm,
  output logic [ADDR_W-1:0] da,
  output logic [3:0]        alpha_row,
  output logic              rp
);

  mode_cfg_t         dec_cfg;
  mode_cfg_t         cfg_q, cfg_d;
  logic              ang_q, ang_d;
  logic              hsn_q;
  logic [ADDR_W-1:0] da_q, da_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [5:0]        byte_cnt_q, byte_cnt_d;
  logic [3:0]        rep_cnt_q, rep_cnt_d;
  logic [3:0]        alpha_row_q, alpha_row_d;
  logic              rp_q, rp_d;
  logic              hsn_fall;
  logic [ADDR_W-1:0] next_row;

  vdg_mode_decode u_mode_decode (
    .ang_i (ang),
    .gm_i  (gm),
    .cfg_o (dec_cfg)
  );

  assign hsn_fall = hsn_q & ~hsn;
  // Start of the next stored row; wraps modulo 2^ADDR_W by construction.
  assign next_row = base_q + ADDR_W'(cfg_q.w);

  always_comb begin
    cfg_d       = cfg_q;
    ang_d       = ang_q;
    da_d        = da_q;
    base_d      = base_q;
    byte_cnt_d  = byte_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    rp_d        = 1'b0;
    alpha_row_d = ang_q ? 4'd0 : alpha_row_q;

    if (!fsn) begin
      cfg_d       = dec_cfg;
      ang_d       = ang;
      da_d        = '0;
      base_d      = '0;
      byte_cnt_d  = '0;
      rep_cnt_d   = '0;
      alpha_row_d = '0;
    end else if (hsn_fall) begin
      // The line just finished is closed out with the geometry it was fetched
      // with; the newly sampled mode governs the following line.
      cfg_d      = dec_cfg;
      ang_d      = ang;
      byte_cnt_d = '0;
      if (rep_cnt_q == cfg_q.r - 4'd1) begin
        rep_cnt_d = '0;
        base_d    = next_row;
        da_d      = next_row;
      end else begin
        rep_cnt_d = rep_cnt_q + 4'd1;
        da_d      = base_q;
      end
      if (!ang_q) begin
        if (alpha_row_q == ALPHA_ROWS - 4'd1) begin
          alpha_row_d = '0;
          rp_d        = 1'b1;
        end else begin
          alpha_row_d = alpha_row_q + 4'd1;
        end
      end
    end else if (preload && (byte_cnt_q < cfg_q.w)) begin
      da_d       = da_q + ADDR_W'(1);
      byte_cnt_d = byte_cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q       <= '{w: ROW_BYTES_32, r: REP_12};
      ang_q       <= 1'b0;
      hsn_q       <= 1'b1;
      da_q        <= '0;
      base_q      <= '0;
      byte_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      alpha_row_q <= '0;
      rp_q        <= 1'b0;
    end else begin
      cfg_q       <= cfg_d;
      ang_q       <= ang_d;
      hsn_q       <= hsn;
      da_q        <= da_d;
      base_q      <= base_d;
      byte_cnt_q  <= byte_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      alpha_row_q <= alpha_row_d;
      rp_q        <= rp_d;
    end
  end

  assign da        = da_q;
  assign alpha_row = alpha_row_q;
  assign rp        = rp_q;

endmodule

// File: tb/tb_display_address_sequencer.sv
// Self-checking bench for display_address_sequencer.
module tb_display_address_sequencer;

  logic        clk;
  logic        reset_n;
  logic        fsn;
  logic        hsn;
  logic        preload;
  logic        ang;
  logic [2:0]  gm;
  logic [12:0] da;
  logic [3:0]  alpha_row;
  logic        rp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       frame;   // pulse fsn with this mode before the line
    logic       ang_v;
    logic [2:0] gm_v;
    int         npre;
    int         peak;    // da after the line's preloads
    int         edge_da; // da after the hsn edge
    int         arow;
    int         rp_v;
  } vec_t;

  typedef struct {
    string name;
    int    da_e;
    int    arow_e;
    int    rp_e;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  display_address_sequencer #(.ADDR_W(13)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .fsn       (fsn),
    .hsn       (hsn),
    .preload   (preload),
    .ang       (ang),
    .gm        (gm),
    .da        (da),
    .alpha_row (alpha_row),
    .rp        (rp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic preloads(input int n);
    for (int i = 0; i < n; i++) begin
      preload = 1'b1;
      step();
    end
    preload = 1'b0;
  endtask

  task automatic frame_pulse(input logic a, input logic [2:0] g);
    ang = a;
    gm  = g;
    fsn = 1'b0;
    step();
    cmp("fsn_clear_da", int'(da), 0);
    fsn = 1'b1;
    step();
  endtask

  // Drives one hsn falling edge; the expected outcome goes to the scoreboard
  // as the edge is driven and is compared once the DUT has registered it.
  task automatic hsn_edge(input string name, input int e_da, input int e_arow,
                          input int e_rp, input logic with_pre);
    exp_t e;
    exp_t got;
    e.name = name; e.da_e = e_da; e.arow_e = e_arow; e.rp_e = e_rp;
    preload = with_pre;
    hsn     = 1'b0;
    sb.push_back(e);
    step();
    if (sb.size() == 0) begin
      cmp({name, "_sb_empty"}, 1, 0);
    end else begin
      got = sb.pop_front();
      cmp({got.name, "_da"}, int'(da), got.da_e);
      cmp({got.name, "_arow"}, int'(alpha_row), got.arow_e);
      cmp({got.name, "_rp"}, int'(rp), got.rp_e);
    end
    preload = 1'b0;
    hsn     = 1'b1;
    step();
    cmp({name, "_rp_one_cycle"}, int'(rp), 0);
  endtask

  task automatic quiet_line(input int n);
    preloads(n);
    hsn = 1'b0;
    step();
    hsn = 1'b1;
    step();
  endtask

  initial begin
    vec_t v;

    // GM6: 32 bytes, every line advances.
    for (int k = 1; k <= 3; k++) begin
      v = '{frame: (k == 1), ang_v: 1'b1, gm_v: 3'd6, npre: 32,
            peak: 32 * k, edge_da: 32 * k, arow: 0, rp_v: 0};
      vecs.push_back(v);
    end
    // GM3: 16 bytes, each row shown twice.
    vecs.push_back('{frame: 1'b1, ang_v: 1'b1, gm_v: 3'd3, npre: 16, peak: 16, edge_da: 0,  arow: 0, rp_v: 0});
    vecs.push_back('{frame: 1'b0, ang_v: 1'b1, gm_v: 3'd3, npre: 16, peak: 16, edge_da: 16, arow: 0, rp_v: 0});
    vecs.push_back('{frame: 1'b0, ang_v: 1'b1, gm_v: 3'd3, npre: 16, peak: 32, edge_da: 16, arow: 0, rp_v: 0});
    vecs.push_back('{frame: 1'b0, ang_v: 1'b1, gm_v: 3'd3, npre: 16, peak: 32, edge_da: 32, arow: 0, rp_v: 0});
    // Alpha: 32 bytes, twelve scanlines per character row.
    for (int k = 1; k <= 24; k++) begin
      v = '{frame: (k == 1), ang_v: 1'b0, gm_v: 3'd0, npre: 32,
            peak: 32 * ((k - 1) / 12) + 32, edge_da: 32 * (k / 12),
            arow: k % 12, rp_v: ((k % 12) == 0) ? 1 : 0};
      vecs.push_back(v);
    end
    // GM1 overrun: 20 preloads against a 16 byte row, first of three repeats.
    vecs.push_back('{frame: 1'b1, ang_v: 1'b1, gm_v: 3'd1, npre: 20, peak: 16, edge_da: 0, arow: 0, rp_v: 0});

    reset_n = 1'b0;
    fsn     = 1'b1;
    hsn     = 1'b1;
    preload = 1'b0;
    ang     = 1'b0;
    gm      = 3'd0;
    step();
    step();
    cmp("reset_da", int'(da), 0);
    cmp("reset_arow", int'(alpha_row), 0);
    cmp("reset_rp", int'(rp), 0);
    reset_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      if (vecs[i].frame) frame_pulse(vecs[i].ang_v, vecs[i].gm_v);
      preloads(vecs[i].npre);
      cmp($sformatf("vec%0d_peak", i), int'(da), vecs[i].peak);
      hsn_edge($sformatf("vec%0d_edge", i), vecs[i].edge_da, vecs[i].arow,
               vecs[i].rp_v, 1'b0);
    end

    // Address wrap at the top of the 13-bit space.
    frame_pulse(1'b1, 3'd7);
    for (int i = 0; i < 255; i++) quiet_line(32);
    cmp("wrap_base_8160", int'(da), 8160);
    preloads(32);
    cmp("wrap_da_after_fetch", int'(da), 0);
    hsn_edge("wrap_edge", 0, 0, 0, 1'b0);

    // Preload coincident with the hsn edge is dropped.
    preloads(5);
    cmp("coinc_pre", int'(da), 5);
    hsn_edge("coinc_edge", 32, 0, 0, 1'b1);
    preloads(1);
    cmp("coinc_next_line", int'(da), 33);

    // Asynchronous reset in the middle of a line.
    frame_pulse(1'b1, 3'd6);
    for (int i = 0; i < 6; i++) quiet_line(32);
    preloads(8);
    cmp("mid_line_da_200", int'(da), 200);
    ang = 1'b0;
    gm  = 3'd0;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    cmp("async_reset_da", int'(da), 0);
    step();
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    step();
    preloads(10);
    cmp("post_reset_fetch", int'(da), 10);
    hsn_edge("post_reset_edge", 0, 1, 0, 1'b0);

    // fsn held low with preloads keeps everything cleared.
    preloads(3);
    fsn = 1'b0;
    ang = 1'b1;
    gm  = 3'd5;
    for (int i = 0; i < 5; i++) begin
      preload = 1'b1;
      step();
      cmp($sformatf("fsn_hold%0d_da", i), int'(da), 0);
      cmp($sformatf("fsn_hold%0d_arow", i), int'(alpha_row), 0);
    end
    fsn = 1'b1;
    step();
    cmp("fsn_release_first_preload", int'(da), 1);
    preloads(3);
    cmp("gm5_partial", int'(da), 4);

    // Mid-line mode change waits for the next line.
    gm = 3'd6;
    preloads(28);
    cmp("gm_change_old_width", int'(da), 16);
    hsn_edge("gm_change_edge", 16, 0, 0, 1'b0);
    preloads(32);
    cmp("gm_change_new_width", int'(da), 48);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
